// File: rtl/uart_ring_dump_ctrl_pkg.sv
// uart_ring_dump_ctrl_pkg: shared ASCII constants, dump FSM state encoding and the
// hex-nibble to ASCII helper used by the ring-buffer dump controller.
package uart_ring_dump_ctrl_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LATCH,
    ST_DIG,
    ST_SEP,
    ST_CR,
    ST_LF,
    ST_WAIT
  } dump_state_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_ZERO + {4'd0, n};
    else           return ASCII_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_ring_dump_ctrl_if.sv
// uart_ring_dump_ctrl_if: UART-side signals of the ring-buffer dump controller.
//   rx_done/rx_data : received word strobe and data (from uart_rx)
//   tx_start/tx_data: character start strobe and character (to uart_tx)
//   tx_done         : character finished strobe (from uart_tx)
// master = controller side, slave = UART side.
interface uart_ring_dump_ctrl_if #(
  parameter int DATA_W = 8
) ();

  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;

  modport master (
    input  rx_done, rx_data, tx_done,
    output tx_start, tx_data
  );

  modport slave (
    output rx_done, rx_data, tx_done,
    input  tx_start, tx_data
  );

endinterface

// File: rtl/uart_ring_dump_ctrl_ram_dp_sync.sv
// ram_dp_sync: DATA_W x 2**ADDR_W storage, one write port and one registered read port.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   raddr : read address, rdata valid the cycle after raddr is presented
// A read of the address being written in the same cycle returns the old contents.
module ram_dp_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_ring_dump_ctrl.sv
// uart_ring_dump_ctrl: stores every received UART word in a 2**ADDR_W ring buffer,
// steps through stored entries for the 7-seg display and dumps the buffer as
// uppercase ASCII hex (SEP between entries, CR LF at the end) over uart_tx.
//   clk, n_rst : clock, asynchronous active-low reset
//   uart       : rx_done/rx_data in, tx_start/tx_data out, tx_done in
//   step, dump : one-cycle request pulses
//   disp_data  : entry shown on the display
//   count      : stored entries (0..DEPTH), overflow: sticky overwrite flag
//   busy       : dump in progress
//
// state    | meaning
// ST_IDLE  | no dump; step logic owns the RAM read port
// ST_RD    | read address for entry k presented to the RAM
// ST_LATCH | RAM output captured into the digit shift register
// ST_DIG   | launch the next hex digit of the entry (MSB first)
// ST_SEP   | launch the separator, advance to next entry
// ST_CR    | launch carriage return
// ST_LF    | launch line feed
// ST_WAIT  | character in flight; resume at after_st on tx_done
module uart_ring_dump_ctrl
  import uart_ring_dump_ctrl_pkg::*;
#(
  parameter int         DATA_W = 8,
  parameter int         ADDR_W = 4,
  parameter logic [7:0] SEP    = ASCII_SPACE
) (
  input  logic                  clk,
  input  logic                  n_rst,
  uart_ring_dump_ctrl_if.master uart,
  input  logic                  step,
  input  logic                  dump,
  output logic [DATA_W-1:0]     disp_data,
  output logic [ADDR_W:0]       count,
  output logic                  busy,
  output logic                  overflow
);

  localparam int NDIG  = DATA_W / 4;
  localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DIG_W-1:0]  LAST_DIG = DIG_W'(NDIG - 1);
  localparam logic [ADDR_W:0]   FULL     = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wptr, sidx, oldest, rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              step_go, step_pend;

  dump_state_t       state, state_nxt, after_st, after_nxt;
  logic [ADDR_W:0]   k, k_nxt, n_snap, n_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [DATA_W-1:0] word, word_nxt;
  logic [DIG_W-1:0]  dig, dig_nxt;
  logic              tx_start_q, tx_start_nxt;
  logic [7:0]        tx_data_q, tx_data_nxt;

  // count==FULL truncates to 0, so oldest == wptr once the buffer has wrapped.
  assign oldest  = wptr - count[ADDR_W-1:0];
  assign busy    = (state != ST_IDLE);
  assign step_go = step && !busy && (count != '0);
  assign rd_addr = busy ? (base + k[ADDR_W-1:0]) : (oldest + sidx);

  assign uart.tx_start = tx_start_q;
  assign uart.tx_data  = tx_data_q;

  ram_dp_sync #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (uart.rx_done),
    .waddr(wptr),
    .wdata(uart.rx_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (uart.rx_done) begin
      wptr <= wptr + 1'b1;
      if (count == FULL) overflow <= 1'b1;
      else               count    <= count + 1'b1;
    end
  end

  // Step read is registered in the RAM, then once more into disp_data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sidx      <= '0;
      step_pend <= 1'b0;
      disp_data <= '0;
    end else begin
      step_pend <= step_go;
      if (step_pend) disp_data <= rd_data;
      if (uart.rx_done && (count == '0))
        sidx <= '0;
      else if (step_go)
        sidx <= (({1'b0, sidx} + 1'b1) == count) ? '0 : sidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      after_st   <= ST_IDLE;
      k          <= '0;
      n_snap     <= '0;
      base       <= '0;
      word       <= '0;
      dig        <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state      <= state_nxt;
      after_st   <= after_nxt;
      k          <= k_nxt;
      n_snap     <= n_nxt;
      base       <= base_nxt;
      word       <= word_nxt;
      dig        <= dig_nxt;
      tx_start_q <= tx_start_nxt;
      tx_data_q  <= tx_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    after_nxt    = after_st;
    k_nxt        = k;
    n_nxt        = n_snap;
    base_nxt     = base;
    word_nxt     = word;
    dig_nxt      = dig;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data_q;
    case (state)
      ST_IDLE: begin
        // count/oldest here are pre-write values, so a same-cycle rx_done is excluded.
        if (dump) begin
          n_nxt     = count;
          base_nxt  = oldest;
          k_nxt     = '0;
          state_nxt = (count == '0) ? ST_CR : ST_RD;
        end
      end
      ST_RD:    state_nxt = ST_LATCH;
      ST_LATCH: begin
        word_nxt  = rd_data;
        dig_nxt   = '0;
        state_nxt = ST_DIG;
      end
      ST_DIG: begin
        tx_start_nxt = 1'b1;
        tx_data_nxt  = hex_ascii(word[DATA_W-1 -: 4]);
        word_nxt     = word << 4;
        dig_nxt      = dig + 1'b1;
        if (dig == LAST_DIG) after_nxt = ((k + 1'b1) < n_snap) ? ST_SEP : ST_CR;
        else                 after_nxt = ST_DIG;
        state_nxt    = ST_WAIT;
      end
      ST_SEP: begin
        tx_start_nxt = 1'b1;
        tx_data_nxt  = SEP;
        k_nxt        = k + 1'b1;
        after_nxt    = ST_RD;
        state_nxt    = ST_WAIT;
      end
      ST_CR: begin
        tx_start_nxt = 1'b1;
        tx_data_nxt  = ASCII_CR;
        after_nxt    = ST_LF;
        state_nxt    = ST_WAIT;
      end
      ST_LF: begin
        tx_start_nxt = 1'b1;
        tx_data_nxt  = ASCII_LF;
        after_nxt    = ST_IDLE;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT:  if (uart.tx_done) state_nxt = after_st;
      default:  state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_ring_dump_ctrl.sv
module tb_uart_ring_dump_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       step;
  logic       dump;
  logic [7:0] disp_data;
  logic [4:0] count;
  logic       busy;
  logic       overflow;

  uart_ring_dump_ctrl_if #(.DATA_W(DATA_W)) u_if ();

  uart_ring_dump_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .SEP   (8'h20)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .uart     (u_if),
    .step     (step),
    .dump     (dump),
    .disp_data(disp_data),
    .count    (count),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: ring contents, write pointer, fill level, step index
  logic [7:0] mem_m [DEPTH];
  int         wptr_m, cnt_m, sidx_m;
  logic       ovf_m;
  logic [7:0] disp_m;
  logic [7:0] exp_q [$];
  logic [7:0] tx_q  [$];

  typedef struct {
    int         op;        // 0 = write din, 1 = step
    logic [7:0] din;
    logic [7:0] exp_disp;
    int         exp_cnt;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] d);
    if (d < 10) return 8'h30 + 8'(d);
    return 8'h41 + 8'(d) - 8'd10;
  endfunction

  function automatic void model_reset();
    wptr_m = 0; cnt_m = 0; sidx_m = 0; ovf_m = 1'b0; disp_m = 8'h00;
  endfunction

  function automatic void model_write(input logic [7:0] d);
    mem_m[wptr_m] = d;
    wptr_m = (wptr_m + 1) % DEPTH;
    if (cnt_m == 0) sidx_m = 0;
    if (cnt_m == DEPTH) ovf_m = 1'b1;
    else                cnt_m++;
  endfunction

  function automatic void build_exp();
    logic [7:0] e;
    exp_q.delete();
    for (int k = 0; k < cnt_m; k++) begin
      e = mem_m[(wptr_m - cnt_m + k + DEPTH) % DEPTH];
      exp_q.push_back(hexc(e[7:4]));
      exp_q.push_back(hexc(e[3:0]));
      if (k < cnt_m - 1) exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic do_write(input logic [7:0] d);
    u_if.rx_data = d;
    u_if.rx_done = 1'b1;
    tick();
    u_if.rx_done = 1'b0;
    model_write(d);
  endtask

  task automatic do_step();
    if (cnt_m != 0) begin
      disp_m = mem_m[(wptr_m - cnt_m + sidx_m + DEPTH) % DEPTH];
      sidx_m = (sidx_m + 1 == cnt_m) ? 0 : sidx_m + 1;
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_start"},  32'(u_if.tx_start), 32'd0);
    chk({tag, "_tx_data"},   32'(u_if.tx_data),  32'd0);
    chk({tag, "_disp_data"}, 32'(disp_data),     32'd0);
    chk({tag, "_count"},     32'(count),         32'd0);
    chk({tag, "_busy"},      32'(busy),          32'd0);
    chk({tag, "_overflow"},  32'(overflow),      32'd0);
  endtask

  task automatic start_dump(input string tag);
    build_exp();
    tx_q.delete();
    dump = 1'b1;
    tick();
    dump = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic finish_dump(input string tag);
    int cyc = 0;
    logic [7:0] a;
    while (busy && cyc < 4000) begin
      tick();
      cyc++;
    end
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_len"}, 32'(tx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      a = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      chk($sformatf("%s_char%0d", tag, i), 32'(a), 32'(exp_q[i]));
    end
  endtask

  // uart_tx stand-in: records characters, answers tx_done after a random delay,
  // and checks handshake rules.
  initial begin
    bit         pending;
    int         delay;
    logic [7:0] held;
    pending = 1'b0;
    delay = 0;
    held = 8'h00;
    u_if.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        pending = 1'b0;
        u_if.tx_done = 1'b0;
      end else begin
        if (u_if.tx_done) begin
          u_if.tx_done = 1'b0;
          pending = 1'b0;
        end else if (pending) begin
          chk("tx_data_stable", 32'(u_if.tx_data), 32'(held));
          if (delay == 0) u_if.tx_done = 1'b1;
          else            delay--;
        end
        if (u_if.tx_start) begin
          chk("tx_start_overlap", 32'(pending), 32'd0);
          tx_q.push_back(u_if.tx_data);
          held = u_if.tx_data;
          pending = 1'b1;
          delay = $urandom_range(0, 3);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ref_3a [7];
    logic [7:0] d;
    int nw, ns, cyc;

    vt[0] = '{1, 8'h00, 8'h00, 0};
    vt[1] = '{0, 8'h11, 8'h00, 1};
    vt[2] = '{0, 8'h22, 8'h00, 2};
    vt[3] = '{0, 8'h33, 8'h00, 3};
    vt[4] = '{1, 8'h00, 8'h11, 3};
    vt[5] = '{1, 8'h00, 8'h22, 3};
    vt[6] = '{1, 8'h00, 8'h33, 3};
    vt[7] = '{1, 8'h00, 8'h11, 3};
    ref_3a = '{8'h33, 8'h41, 8'h20, 8'h43, 8'h35, 8'h0D, 8'h0A};

    n_rst = 1'b0;
    step = 1'b0;
    dump = 1'b0;
    u_if.rx_done = 1'b0;
    u_if.rx_data = 8'h00;
    model_reset();
    tick();
    tick();
    check_reset_outputs("reset");
    n_rst = 1'b1;
    tick();

    // empty buffer dump: CR LF only
    start_dump("empty");
    finish_dump("empty");
    chk("empty_first", 32'(tx_q.size() > 0 ? tx_q[0] : 8'hxx), 32'h0D);
    chk("empty_overflow", 32'(overflow), 32'd0);

    // table: step on empty, three writes, four steps
    for (int i = 0; i < 8; i++) begin
      if (vt[i].op == 0) do_write(vt[i].din);
      else               do_step();
      chk($sformatf("vec%0d_disp", i),  32'(disp_data), 32'(vt[i].exp_disp));
      chk($sformatf("vec%0d_count", i), 32'(count),     32'(vt[i].exp_cnt));
    end

    // "3A C5\r\n"
    do_reset();
    do_write(8'h3A);
    do_write(8'hC5);
    start_dump("d3a");
    finish_dump("d3a");
    for (int i = 0; i < 7; i++)
      chk($sformatf("d3a_const%0d", i), 32'(i < tx_q.size() ? tx_q[i] : 8'hxx), 32'(ref_3a[i]));

    // DEPTH+2 writes: wrap and overflow
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) do_write(8'(i));
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    start_dump("ovf");
    finish_dump("ovf");
    chk("ovf_len49", 32'(tx_q.size()), 32'd49);
    chk("ovf_c0", 32'(tx_q.size() > 1 ? tx_q[0] : 8'hxx), 32'h30);
    chk("ovf_c1", 32'(tx_q.size() > 1 ? tx_q[1] : 8'hxx), 32'h32);

    // write and second dump pulse during a dump
    do_reset();
    for (int i = 0; i < 3; i++) do_write(8'($urandom));
    start_dump("mid");
    repeat (6) tick();
    d = 8'($urandom);
    u_if.rx_data = d;
    u_if.rx_done = 1'b1;
    dump = 1'b1;
    tick();
    u_if.rx_done = 1'b0;
    dump = 1'b0;
    model_write(d);
    chk("mid_count", 32'(count), 32'd4);
    finish_dump("mid");
    chk("mid_len10", 32'(tx_q.size()), 32'd10);
    chk("mid_overflow", 32'(overflow), 32'd0);

    // reset while a character is in flight
    do_reset();
    do_write(8'h5E);
    do_write(8'hA7);
    start_dump("rst");
    cyc = 0;
    while (!u_if.tx_start && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("rst_saw_tx_start", 32'(u_if.tx_start), 32'd1);
    n_rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    n_rst = 1'b1;
    model_reset();
    tick();
    do_write(8'h9B);
    start_dump("after_rst");
    finish_dump("after_rst");

    // randomized rounds against the model
    for (int r = 0; r < 10; r++) begin
      nw = $urandom_range(0, 20);
      for (int i = 0; i < nw; i++) do_write(8'($urandom));
      chk($sformatf("rnd%0d_count", r),    32'(count),    32'(cnt_m));
      chk($sformatf("rnd%0d_overflow", r), 32'(overflow), 32'(ovf_m));
      ns = $urandom_range(0, 5);
      for (int i = 0; i < ns; i++) begin
        do_step();
        chk($sformatf("rnd%0d_step%0d", r, i), 32'(disp_data), 32'(disp_m));
      end
      start_dump($sformatf("rnd%0d", r));
      finish_dump($sformatf("rnd%0d", r));
      if (r == 4) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
